// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the multi-channel input conditioner.
package input_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // Width of the debounce counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/input_channel.sv
// One conditioned input: synchroniser, consecutive-sample debounce, polarity fix, edge pulses.
module input_channel
  import input_pkg::*;
#(
  parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int                 CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   level_r;
  logic                   rise_r;
  logic                   fall_r;

  logic                   samp_s;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_nxt_s;
  logic                   rise_nxt_s;
  logic                   fall_nxt_s;

  // Synchroniser chain: always shifts; reset loads the idle pin level so an
  // inactive inverted pin does not look like a fresh edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{INVERT}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  // Debounce decision: count consecutive samples that disagree with the held level.
  always_comb begin
    samp_s      = sync_r[SYNC_STAGES-1] ^ INVERT;
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    if (enable) begin
      if (samp_s == level_r) begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        level_nxt_s = samp_s;
        rise_nxt_s  = samp_s;
        fall_nxt_s  = ~samp_s;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      level_nxt_s = level_r;
    end
  end

  // Filter state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: one independent input_channel per raw pin.
module input_conditioner
  import input_pkg::*;
#(
  parameter int                  CHANNELS        = 4,
  parameter int                  SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int                  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [CHANNELS-1:0] INVERT_MASK     = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (INVERT_MASK[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .raw    (raw_in[i]),
      .level  (level_out[i]),
      .rise   (rise_pulse[i]),
      .fall   (fall_pulse[i])
    );
  end

  // Summary flag, built only from registered pulse bits.
  assign any_change = |(rise_pulse | fall_pulse);

endmodule
